// File: rtl/icache_if.sv
// Fetch-side and bridge-side signal bundle for the two-way instruction cache.
// master: IF stage / bridge driver side; slave: the cache itself.
interface icache_if;
  logic        valid;
  logic        op;
  logic [7:0]  index;
  logic [19:0] tag;
  logic [3:0]  offset;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        rd_req;
  logic [2:0]  rd_type;
  logic [31:0] rd_addr;
  logic        rd_rdy;
  logic        ret_valid;
  logic        ret_last;
  logic [31:0] ret_data;

  modport master (
    output valid, op, index, tag, offset,
    output rd_rdy, ret_valid, ret_last, ret_data,
    input  addr_ok, data_ok, rdata,
    input  rd_req, rd_type, rd_addr
  );

  modport slave (
    input  valid, op, index, tag, offset,
    input  rd_rdy, ret_valid, ret_last, ret_data,
    output addr_ok, data_ok, rdata,
    output rd_req, rd_type, rd_addr
  );
endinterface

// File: rtl/icache.sv
// Two-way set-associative read-only icache: 256 sets, 16-byte lines.
// Ports: clk, reset (async, active-high), bus (icache_if.slave).
module icache (
  input logic   clk,
  input logic   reset,
  icache_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE, LOOKUP, MISS, REFILL, RESPOND
  } state_t;

  state_t      state;
  logic [255:0] vld [2];
  logic [255:0] lru;
  logic [19:0] tags [2][256];
  logic [31:0] mem [2][256][4];
  logic [31:0] rbuf [4];

  logic [19:0] r_tag;
  logic [7:0]  r_idx;
  logic [1:0]  r_wrd;
  logic        victim;
  logic [1:0]  cnt;

  logic hit0, hit1, hit, look_hit;
  logic accept, fill;
  logic [2:0] unused_in;

  // op=1 is served as a read; byte lanes are irrelevant for fetch
  assign unused_in = {bus.op, bus.offset[1:0]};

  assign hit0 = vld[0][r_idx] && (tags[0][r_idx] == r_tag);
  assign hit1 = vld[1][r_idx] && (tags[1][r_idx] == r_tag);
  assign hit  = hit0 || hit1;
  assign look_hit = (state == LOOKUP) && hit;

  assign accept = bus.valid && bus.addr_ok;
  assign fill   = (state == REFILL) && bus.ret_valid;

  assign bus.addr_ok = !reset &&
    ((state == IDLE) || look_hit);
  assign bus.data_ok = look_hit || (state == RESPOND);
  assign bus.rd_req  = (state == MISS);
  assign bus.rd_type = 3'b100;
  assign bus.rd_addr = {r_tag, r_idx, 4'b0000};

  always_comb begin
    bus.rdata = '0;
    unique case (1'b1)
      state == RESPOND: bus.rdata = rbuf[r_wrd];
      look_hit && hit1: bus.rdata = mem[1][r_idx][r_wrd];
      look_hit && hit0: bus.rdata = mem[0][r_idx][r_wrd];
      default:          bus.rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      vld[0] <= '0;
      vld[1] <= '0;
      lru    <= '0;
      cnt    <= '0;
      victim <= 1'b0;
      r_tag  <= '0;
      r_idx  <= '0;
      r_wrd  <= '0;
    end else begin
      if (accept) begin
        r_tag <= bus.tag;
        r_idx <= bus.index;
        r_wrd <= bus.offset[3:2];
      end
      unique case (state)
        IDLE: begin
          if (bus.valid) state <= LOOKUP;
        end
        LOOKUP: begin
          if (hit) begin
            // next victim is the way not just used
            lru[r_idx] <= hit0;
            state <= bus.valid ? LOOKUP : IDLE;
          end else begin
            if (!vld[0][r_idx])      victim <= 1'b0;
            else if (!vld[1][r_idx]) victim <= 1'b1;
            else                     victim <= lru[r_idx];
            state <= MISS;
          end
        end
        MISS: begin
          if (bus.rd_rdy) begin
            cnt   <= '0;
            state <= REFILL;
          end
        end
        REFILL: begin
          if (bus.ret_valid) begin
            cnt <= cnt + 2'd1;
            if (bus.ret_last) begin
              vld[victim][r_idx] <= 1'b1;
              lru[r_idx] <= !victim;
              state <= RESPOND;
            end
          end
        end
        RESPOND: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // arrays carry no reset; valid bits gate their use
  always_ff @(posedge clk) begin
    if (fill) begin
      mem[victim][r_idx][cnt] <= bus.ret_data;
      rbuf[cnt] <= bus.ret_data;
      if (bus.ret_last) tags[victim][r_idx] <= r_tag;
    end
  end
endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: misses, hits, LRU, stalls, reset.
// Inputs driven on negedge, outputs sampled 1 time unit later.
module tb_icache;
  logic clk;
  logic reset;
  int total;
  int bad;

  icache_if bus ();

  icache u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drive(input logic [31:0] a);
    bus.valid  = 1'b1;
    bus.tag    = a[31:12];
    bus.index  = a[11:4];
    bus.offset = a[3:0];
  endtask

  task automatic miss_seq(input logic [31:0] a,
                          input logic [31:0] w0, w1, w2, w3,
                          input int s);
    logic [31:0] w [4];
    logic [31:0] la;
    logic [31:0] ex;
    w  = '{w0, w1, w2, w3};
    la = {a[31:4], 4'b0000};
    ex = w[a[3:2]];
    @(negedge clk); drive(a); #1;
    total++;
    if (bus.addr_ok !== 1'b1) begin
      bad++;
      $display("FAIL miss_accept %h: addr_ok=%b want 1", a, bus.addr_ok);
    end
    @(negedge clk); bus.valid = 1'b0; #1;
    total++;
    if (bus.data_ok !== 1'b0 || bus.addr_ok !== 1'b0) begin
      bad++;
      $display("FAIL lookup_miss %h: data_ok=%b addr_ok=%b want 0 0",
               a, bus.data_ok, bus.addr_ok);
    end
    for (int i = 0; i <= s; i++) begin
      @(negedge clk); bus.rd_rdy = (i == s); #1;
      total++;
      if (bus.rd_req !== 1'b1 || bus.rd_addr !== la ||
          bus.rd_type !== 3'b100 || bus.addr_ok !== 1'b0) begin
        bad++;
        $display("FAIL rd_req %h cyc%0d: req=%b addr=%h type=%b aok=%b want 1 %h 100 0",
                 a, i, bus.rd_req, bus.rd_addr, bus.rd_type, bus.addr_ok, la);
      end
    end
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      bus.rd_rdy = 1'b0;
      bus.ret_valid = 1'b1;
      bus.ret_last = (b == 3);
      bus.ret_data = w[b];
      #1;
      total++;
      if (bus.data_ok !== 1'b0 || bus.rd_req !== 1'b0) begin
        bad++;
        $display("FAIL refill_beat%0d %h: data_ok=%b rd_req=%b want 0 0",
                 b, a, bus.data_ok, bus.rd_req);
      end
    end
    @(negedge clk); bus.ret_valid = 1'b0; bus.ret_last = 1'b0; #1;
    total++;
    if (bus.data_ok !== 1'b1 || bus.rdata !== ex || bus.addr_ok !== 1'b0) begin
      bad++;
      $display("FAIL respond %h: data_ok=%b rdata=%h aok=%b want 1 %h 0",
               a, bus.data_ok, bus.rdata, bus.addr_ok, ex);
    end
    @(negedge clk); #1;
    total++;
    if (bus.data_ok !== 1'b0 || bus.addr_ok !== 1'b1) begin
      bad++;
      $display("FAIL after_respond %h: data_ok=%b aok=%b want 0 1",
               a, bus.data_ok, bus.addr_ok);
    end
  endtask

  task automatic hit_one(input logic [31:0] a, input logic [31:0] ex);
    @(negedge clk); drive(a); #1;
    total++;
    if (bus.addr_ok !== 1'b1) begin
      bad++;
      $display("FAIL hit_accept %h: addr_ok=%b want 1", a, bus.addr_ok);
    end
    @(negedge clk); bus.valid = 1'b0; #1;
    total++;
    if (bus.data_ok !== 1'b1 || bus.rdata !== ex || bus.rd_req !== 1'b0) begin
      bad++;
      $display("FAIL hit %h: data_ok=%b rdata=%h rd_req=%b want 1 %h 0",
               a, bus.data_ok, bus.rdata, bus.rd_req, ex);
    end
    @(negedge clk); #1;
    total++;
    if (bus.data_ok !== 1'b0 || bus.addr_ok !== 1'b1) begin
      bad++;
      $display("FAIL hit_idle %h: data_ok=%b aok=%b want 0 1",
               a, bus.data_ok, bus.addr_ok);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.valid = 1'b0; bus.op = 1'b0;
    bus.tag = '0; bus.index = '0; bus.offset = '0;
    bus.rd_rdy = 1'b0; bus.ret_valid = 1'b0;
    bus.ret_last = 1'b0; bus.ret_data = '0;
    @(negedge clk); #1;
    total++;
    if (bus.addr_ok !== 1'b0 || bus.data_ok !== 1'b0 || bus.rdata !== 32'h0 ||
        bus.rd_req !== 1'b0 || bus.rd_addr !== 32'h0) begin
      bad++;
      $display("FAIL reset_vals: aok=%b dok=%b rdata=%h req=%b addr=%h want all 0",
               bus.addr_ok, bus.data_ok, bus.rdata, bus.rd_req, bus.rd_addr);
    end
    reset = 1'b0;
    @(negedge clk); #1;
    total++;
    if (bus.addr_ok !== 1'b1 || bus.data_ok !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: aok=%b dok=%b want 1 0", bus.addr_ok, bus.data_ok);
    end
  endtask

  task automatic test_cold_miss;
    miss_seq(32'hbfc00000, 32'h11, 32'h22, 32'h33, 32'h44, 0);
  endtask

  task automatic test_hit_stream;
    logic [31:0] ad [3];
    logic [31:0] ex [3];
    ad = '{32'hbfc00004, 32'hbfc00008, 32'hbfc0000c};
    ex = '{32'h22, 32'h33, 32'h44};
    @(negedge clk); drive(ad[0]); #1;
    total++;
    if (bus.addr_ok !== 1'b1) begin
      bad++;
      $display("FAIL stream_accept0: addr_ok=%b want 1", bus.addr_ok);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i < 2) drive(ad[i+1]);
      else bus.valid = 1'b0;
      #1;
      total++;
      if (bus.data_ok !== 1'b1 || bus.rdata !== ex[i] ||
          bus.addr_ok !== 1'b1 || bus.rd_req !== 1'b0) begin
        bad++;
        $display("FAIL stream%0d: dok=%b rdata=%h aok=%b req=%b want 1 %h 1 0",
                 i, bus.data_ok, bus.rdata, bus.addr_ok, bus.rd_req, ex[i]);
      end
    end
    @(negedge clk); #1;
    total++;
    if (bus.data_ok !== 1'b0) begin
      bad++;
      $display("FAIL stream_end: data_ok=%b want 0", bus.data_ok);
    end
  endtask

  task automatic test_offset;
    hit_one(32'hbfc00006, 32'h22);
  endtask

  task automatic test_lru;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    miss_seq(32'h00001000, 32'ha0, 32'ha1, 32'ha2, 32'ha3, 0);
    miss_seq(32'h00002000, 32'hb0, 32'hb1, 32'hb2, 32'hb3, 0);
    hit_one(32'h00001000, 32'ha0);
    miss_seq(32'h00003008, 32'hc0, 32'hc1, 32'hc2, 32'hc3, 0);
    hit_one(32'h00001004, 32'ha1);
    hit_one(32'h0000300c, 32'hc3);
    miss_seq(32'h00002000, 32'hd0, 32'hd1, 32'hd2, 32'hd3, 0);
  endtask

  task automatic test_stall;
    miss_seq(32'h00004014, 32'he0, 32'he1, 32'he2, 32'he3, 5);
    hit_one(32'h00004018, 32'he2);
  endtask

  task automatic test_reset_mid;
    // reset while waiting on the bridge
    @(negedge clk); drive(32'h00006030);
    @(negedge clk); bus.valid = 1'b0;
    @(negedge clk); #1;
    total++;
    if (bus.rd_req !== 1'b1) begin
      bad++;
      $display("FAIL mid_miss_req: rd_req=%b want 1", bus.rd_req);
    end
    #1 reset = 1'b1;
    #1;
    total++;
    if (bus.rd_req !== 1'b0 || bus.rd_addr !== 32'h0 || bus.addr_ok !== 1'b0) begin
      bad++;
      $display("FAIL mid_miss_reset: req=%b addr=%h aok=%b want 0 0 0",
               bus.rd_req, bus.rd_addr, bus.addr_ok);
    end
    @(negedge clk); reset = 1'b0;
    // reset after two refill beats
    @(negedge clk); drive(32'h00005020);
    @(negedge clk); bus.valid = 1'b0;
    @(negedge clk); bus.rd_rdy = 1'b1;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      bus.rd_rdy = 1'b0;
      bus.ret_valid = 1'b1;
      bus.ret_data = 32'h70 + b;
    end
    @(negedge clk); bus.ret_valid = 1'b0; #1;
    reset = 1'b1;
    #1;
    total++;
    if (bus.rd_req !== 1'b0 || bus.addr_ok !== 1'b0 || bus.data_ok !== 1'b0 ||
        bus.rdata !== 32'h0 || bus.rd_addr !== 32'h0) begin
      bad++;
      $display("FAIL mid_refill_reset: req=%b aok=%b dok=%b rdata=%h addr=%h want 0",
               bus.rd_req, bus.addr_ok, bus.data_ok, bus.rdata, bus.rd_addr);
    end
    @(negedge clk); reset = 1'b0;
    miss_seq(32'h00005024, 32'hf0, 32'hf1, 32'hf2, 32'hf3, 1);
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_cold_miss();
    test_hit_stream();
    test_offset();
    test_lru();
    test_stall();
    test_reset_mid();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/icache.md
# icache

Two-way set-associative, read-only instruction cache sitting between the IF stage and the AXI bridge. It accepts fetch requests split into tag/index/offset, answers hits one cycle after acceptance, and on a miss refills a 16-byte line from the bridge before answering. It is the responder end of the IF-stage fetch handshake (`valid`/`addr_ok`/`data_ok`).

## Interface
- No parameters; geometry is fixed: 256 sets, 2 ways, 16-byte line (4 words), 20-bit tag.
- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `valid`  in  1  fetch request present
- `op`  in  1  0 = read; 1 is not supported and is treated as read
- `index`  in  8  set index (addr[11:4])
- `tag`  in  20  address tag (addr[31:12])
- `offset`  in  4  byte offset in line; word select = offset[3:2], offset[1:0] ignored
- `addr_ok`  out  1  request accepted this cycle
- `data_ok`  out  1  `rdata` valid this cycle
- `rdata`  out  32  instruction word
- `rd_req`  out  1  line read request to bridge
- `rd_type`  out  3  always 3'b100 (cache line)
- `rd_addr`  out  32  `{tag, index, 4'b0000}` of missing line
- `rd_rdy`  in  1  bridge accepts `rd_req`
- `ret_valid`  in  1  refill beat valid
- `ret_last`  in  1  final refill beat
- `ret_data`  in  32  refill word, beats in ascending word order

## Operation
- Storage per way per set: valid bit, 20-bit tag, 4 x 32-bit data. One LRU bit per set (0 = way0 is victim).
- Request register captures `{tag,index,offset}` on every accepted request (`valid & addr_ok`).
- States: IDLE, LOOKUP, MISS, REFILL, RESPOND.
- IDLE: `addr_ok = 1`. `valid` -> capture, go LOOKUP; else stay.
- LOOKUP: compare captured tag against both ways of captured set; hit = valid & tag match.
  - Hit: `data_ok = 1`, `rdata` = selected way word `offset[3:2]`; LRU set to point at the other way; `addr_ok = 1` so a new request may be captured same cycle (stay LOOKUP if `valid`, else IDLE).
  - Miss: `addr_ok = 0`, go MISS. Victim = first invalid way (way0 preferred), else LRU way; latched on entering MISS.
- MISS: `rd_req = 1`, `rd_addr` = captured line address. Hold until `rd_rdy`, then REFILL.
- REFILL: each `ret_valid` writes `ret_data` into victim way at beat counter (2-bit, starts 0, increments per beat) and a 4-word refill buffer. On `ret_valid & ret_last`: write tag, set valid, set LRU to other way, go RESPOND.
- RESPOND: `data_ok = 1`, `rdata` = refill buffer word `offset[3:2]`; `addr_ok = 0`; go IDLE.
- `addr_ok` is 0 in MISS, REFILL, RESPOND, and in LOOKUP on miss. `rd_req` only in MISS. `data_ok` only on LOOKUP-hit or RESPOND.
- `ret_valid` outside REFILL is ignored. `ret_last` before 4 beats completes the line anyway (counter not checked).

## Timing
- Reset (async): state IDLE, all valid and LRU bits 0, beat counter 0, `data_ok = 0`, `rdata = 0`, `rd_req = 0`, `rd_addr = 0`, `addr_ok = 0` while `reset` is high.
- Hit latency: `data_ok` one cycle after the `addr_ok` cycle. Back-to-back hits sustain one word per cycle.
- Miss latency: accept (T0), LOOKUP miss (T1), `rd_req` from T2 until `rd_rdy`, then beats; `data_ok` the cycle after the `ret_last` beat.
- `rd_req`/`rd_addr` stable from MISS entry until the `rd_rdy` cycle inclusive.
- Reset asserted mid-miss or mid-refill: immediate return to IDLE, partial line never marked valid, `rd_req` drops asynchronously.
- Same-set request while previous line refilling: impossible (`addr_ok = 0`); next request looks up after refill, so it hits on the new line.
- Outputs `data_ok`, `rdata`, `addr_ok`, `rd_req` are combinational from state and arrays; no output depends combinationally on `valid` except via state.

## Test plan
- Cold miss: reset, request addr 0xbfc00000 -> `rd_req` with `rd_addr = 0xbfc00000`, `rd_type = 3'b100`; return words 0x11,0x22,0x33,0x44 -> `data_ok` with `rdata = 0x11` cycle after `ret_last`.
- Hit streaming: then requests 0xbfc00004, 0xbfc00008, 0xbfc0000c with `valid` held -> `addr_ok` every cycle, `rdata` 0x22, 0x33, 0x44 on consecutive cycles, no `rd_req`.
- Way fill and LRU: misses to 0x00001000 and 0x00002000 (index 0), access 0x00001000, then miss to 0x00003000 -> victim is the 0x00002000 way; 0x00001000 still hits, 0x00002000 misses.
- Bridge stall: hold `rd_rdy = 0` for 5 cycles -> `rd_req`/`rd_addr` steady, `addr_ok = 0`; single `data_ok` after refill.
- Reset mid-refill: assert `reset` after 2 beats -> outputs to reset values immediately; re-request same address misses again.
- Offset select: request 0xbfc00006 (offset[1:0]=2'b10) after line loaded -> `rdata` = word 1 (0x22).
